// File: rtl/if_fetch.sv
// Instruction fetch stage: one outstanding imem request, single-entry hold buffer, halt and redirect handling.
// Optional performance counters are built only when IF_FETCH_PERF_EN is defined.
module if_fetch (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        halt_i,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] ins_o,
  output logic [31:0] pc_o,
  output logic        ins_valid,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_stall_cnt
);

  localparam int unsigned XLEN = 32;
  localparam logic [XLEN-1:0] HALT_INS = XLEN'(32'h0000_000C);
  localparam logic [XLEN-1:0] PC_STEP  = XLEN'(4);
  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    HOLD   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [XLEN-1:0]   pc, pc_nxt;
  logic [XLEN-1:0]   ibuf, ibuf_nxt;
  logic              consume;

  // State, pc and buffer registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
      pc    <= '0;
      ibuf  <= '0;
    end else begin
      state <= state_nxt;
      pc    <= pc_nxt;
      ibuf  <= ibuf_nxt;
    end
  end

  // Next state and fetch-side outputs; presentation is combinational so a
  // returning word reaches IF/ID in the same cycle it arrives.
  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    ibuf_nxt  = ibuf;
    imem_req  = 1'b0;
    ins_o     = '0;
    ins_valid = 1'b0;
    consume   = 1'b0;

    if (!rst) begin
      case (state)
        FETCH: begin
          imem_req = 1'b1;
          if (imem_ready && !redirect) begin
            ins_o     = imem_rdata;
            ins_valid = 1'b1;
          end
        end
        HOLD: begin
          if (!redirect) begin
            ins_o     = ibuf;
            ins_valid = 1'b1;
          end
        end
        HALTED: begin
          ins_o = HALT_INS;
        end
        default: begin
          state_nxt = FETCH;
        end
      endcase

      // A halt request blocks consumption even when decode is ready
      consume = ins_valid && !stall && !halt_i;

      if (redirect) begin
        pc_nxt    = redirect_pc & ALIGN_MASK;
        ibuf_nxt  = '0;
        state_nxt = FETCH;
      end else if (halt_i) begin
        ibuf_nxt  = '0;
        state_nxt = HALTED;
      end else if (consume) begin
        pc_nxt    = pc + PC_STEP;
        state_nxt = FETCH;
      end else if (state == FETCH && imem_ready && stall) begin
        ibuf_nxt  = imem_rdata;
        state_nxt = HOLD;
      end
    end
  end

  assign imem_addr = pc;
  assign pc_o      = pc;

`ifdef IF_FETCH_PERF_EN
  logic [XLEN-1:0] fetch_cnt;
  logic [XLEN-1:0] stall_cnt;

  // Consumed-instruction and stalled-presentation counters, wrapping
  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_cnt <= '0;
      stall_cnt <= '0;
    end else begin
      if (consume) begin
        fetch_cnt <= fetch_cnt + XLEN'(1);
      end
      if (ins_valid && stall) begin
        stall_cnt <= stall_cnt + XLEN'(1);
      end
    end
  end

  assign perf_fetch_cnt = fetch_cnt;
  assign perf_stall_cnt = stall_cnt;
`else
  assign perf_fetch_cnt = '0;
  assign perf_stall_cnt = '0;
`endif

endmodule

// File: tb/tb_if_fetch.sv
// Directed, table-driven bench for if_fetch: one row per cycle, outputs checked mid-cycle.
module tb_if_fetch;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        halt_i;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] ins_o;
  logic [31:0] pc_o;
  logic        ins_valid;
  logic [31:0] perf_fetch_cnt;
  logic [31:0] perf_stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  if_fetch dut (
    .clk            (clk),
    .rst            (rst),
    .stall          (stall),
    .halt_i         (halt_i),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rdata     (imem_rdata),
    .ins_o          (ins_o),
    .pc_o           (pc_o),
    .ins_valid      (ins_valid),
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        stall;
    logic        halt;
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic [31:0] e_ins;
    logic [31:0] e_pc;
    logic        e_valid;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic r, input logic s, input logic h, input logic rd,
                     input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata,
                     input logic e_req, input logic [31:0] e_addr, input logic [31:0] e_ins,
                     input logic [31:0] e_pc, input logic e_valid);
    vec_t v;
    v.rst = r; v.stall = s; v.halt = h; v.redir = rd; v.rpc = rpc; v.rdy = rdy; v.rdata = rdata;
    v.e_req = e_req; v.e_addr = e_addr; v.e_ins = e_ins; v.e_pc = e_pc; v.e_valid = e_valid;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic s, input logic h, input logic rd,
                       input logic [31:0] rpc, input logic rdy, input logic [31:0] rdata);
    rst = r; stall = s; halt_i = h; redirect = rd; redirect_pc = rpc;
    imem_ready = rdy; imem_rdata = rdata;
  endtask

  initial begin
    drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);

    //   rst stall halt redir rpc            rdy rdata           req addr           ins             pc             valid
    add(1, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,          1, 32'h0000_0093,  1, 32'h0000_0000, 32'h0000_0093,  32'h0000_0000, 1);
    add(0, 0, 0, 0, 32'h0,          1, 32'h0010_0113,  1, 32'h0000_0004, 32'h0010_0113,  32'h0000_0004, 1);
    add(0, 0, 0, 0, 32'h0,          1, 32'h0020_0193,  1, 32'h0000_0008, 32'h0020_0193,  32'h0000_0008, 1);
    add(0, 0, 0, 0, 32'h0,          1, 32'h0030_0213,  1, 32'h0000_000C, 32'h0030_0213,  32'h0000_000C, 1);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0010, 32'h0,          32'h0000_0010, 0);
    // stall three cycles at 0x10, then release
    add(0, 1, 0, 0, 32'h0,          1, 32'h0040_0293,  1, 32'h0000_0010, 32'h0040_0293,  32'h0000_0010, 1);
    add(0, 1, 0, 0, 32'h0,          1, 32'hDEAD_BEEF,  0, 32'h0000_0010, 32'h0040_0293,  32'h0000_0010, 1);
    add(0, 1, 0, 0, 32'h0,          1, 32'hDEAD_BEEF,  0, 32'h0000_0010, 32'h0040_0293,  32'h0000_0010, 1);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0010, 32'h0040_0293,  32'h0000_0010, 1);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0014, 32'h0,          32'h0000_0014, 0);
    // buffer a word, then redirect out of HOLD to 0x103 (aligned to 0x100)
    add(0, 1, 0, 0, 32'h0,          1, 32'h0050_0313,  1, 32'h0000_0014, 32'h0050_0313,  32'h0000_0014, 1);
    add(0, 1, 0, 1, 32'h0000_0103,  0, 32'h0,          0, 32'h0000_0014, 32'h0,          32'h0000_0014, 0);
    add(0, 0, 0, 0, 32'h0,          1, 32'h1000_0393,  1, 32'h0000_0100, 32'h1000_0393,  32'h0000_0100, 1);
    // redirect while a response returns: response dropped, pc not advanced
    add(0, 0, 0, 1, 32'h0000_0200,  1, 32'h1040_0413,  1, 32'h0000_0104, 32'h0,          32'h0000_0104, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0200, 32'h0,          32'h0000_0200, 0);
    // halt and stall together
    add(0, 1, 1, 0, 32'h0,          1, 32'h2000_0493,  1, 32'h0000_0200, 32'h2000_0493,  32'h0000_0200, 1);
    add(0, 1, 0, 0, 32'h0,          1, 32'h2000_0493,  0, 32'h0000_0200, 32'h0000_000C,  32'h0000_0200, 0);
    add(0, 0, 0, 0, 32'h0,          1, 32'h2000_0493,  0, 32'h0000_0200, 32'h0000_000C,  32'h0000_0200, 0);
    add(0, 0, 0, 1, 32'h0000_0040,  0, 32'h0,          0, 32'h0000_0200, 32'h0000_000C,  32'h0000_0200, 0);
    add(0, 0, 0, 0, 32'h0,          1, 32'h0400_0513,  1, 32'h0000_0040, 32'h0400_0513,  32'h0000_0040, 1);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0044, 32'h0,          32'h0000_0044, 0);
    // wrap at the top of the address space
    add(0, 0, 0, 1, 32'hFFFF_FFFE,  0, 32'h0,          1, 32'h0000_0044, 32'h0,          32'h0000_0044, 0);
    add(0, 0, 0, 0, 32'h0,          1, 32'hFFC0_0593,  1, 32'hFFFF_FFFC, 32'hFFC0_0593,  32'hFFFF_FFFC, 1);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);
    // reset while waiting at 0x20
    add(0, 0, 0, 1, 32'h0000_0020,  0, 32'h0,          1, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0020, 32'h0,          32'h0000_0020, 0);
    add(1, 1, 1, 1, 32'h0000_0300,  1, 32'hBAD0_BAD0,  0, 32'h0000_0020, 32'h0,          32'h0000_0020, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);
    // reset while in HOLD
    add(0, 1, 0, 0, 32'h0,          1, 32'h0060_0613,  1, 32'h0000_0000, 32'h0060_0613,  32'h0000_0000, 1);
    add(1, 1, 0, 0, 32'h0,          0, 32'h0,          0, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);
    add(0, 0, 0, 0, 32'h0,          0, 32'h0,          1, 32'h0000_0000, 32'h0,          32'h0000_0000, 0);

    repeat (2) @(posedge clk);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      drive(vecs[i].rst, vecs[i].stall, vecs[i].halt, vecs[i].redir, vecs[i].rpc,
            vecs[i].rdy, vecs[i].rdata);
      #1;
      check($sformatf("row%0d imem_req", i),  32'(imem_req),  32'(vecs[i].e_req));
      check($sformatf("row%0d imem_addr", i), imem_addr,      vecs[i].e_addr);
      check($sformatf("row%0d ins_o", i),     ins_o,          vecs[i].e_ins);
      check($sformatf("row%0d pc_o", i),      pc_o,           vecs[i].e_pc);
      check($sformatf("row%0d ins_valid", i), 32'(ins_valid), 32'(vecs[i].e_valid));
`ifndef IF_FETCH_PERF_EN
      check($sformatf("row%0d perf_fetch", i), perf_fetch_cnt, 32'h0);
      check($sformatf("row%0d perf_stall", i), perf_stall_cnt, 32'h0);
`endif
    end

`ifdef IF_FETCH_PERF_EN
    // Five consumes and two stalled presentations after a fresh reset
    @(negedge clk); drive(1, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check("perf_fetch after rst", perf_fetch_cnt, 32'h0);
    check("perf_stall after rst", perf_stall_cnt, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 1, 32'h0000_0013);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 1, 32'h0000_0013);
    @(negedge clk); drive(0, 1, 0, 0, 32'h0, 1, 32'h0000_0013);
    @(negedge clk); drive(0, 1, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 1, 32'h0000_0013);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 1, 32'h0000_0013);
    @(negedge clk); drive(0, 0, 0, 0, 32'h0, 0, 32'h0);
    #1;
    check("perf_fetch count", perf_fetch_cnt, 32'd5);
    check("perf_stall count", perf_stall_cnt, 32'd2);
    check("perf pc", pc_o, 32'h0000_0014);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
